trenc_atb_funnel: RTL and testbench

- ATB funnel directly downstream of the per-core trace encoder ATB masters (trenc_atvalid_o/trenc_atdata_o/...).
- Merges up to NUM_SRC encoder ATB streams into one ATB master toward the trace sink or replicator.
- Round-robin arbitration with bounded burst hold, one registered output slice, pass-through ATID.
- Fans the sink flush request (afvalid) out to all enabled sources and acknowledges once every source and the slice are drained.

---
 rtl/trenc_pkg.sv | 28 ++
 rtl/trenc_rr_arb.sv | 64 ++++++
 rtl/trenc_atb_funnel.sv | 135 +++++++++++++
 tb/tb_trenc_atb_funnel.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trenc_pkg.sv
// Shared trace-encoder types and constants: ATB ID field, the funnel's beat layout and flush FSM states.
package trenc_pkg;

   localparam int ATB_ID_W = 7;
   localparam logic [ATB_ID_W-1:0] ATB_ID_RSVD_LO = 7'h70;
   localparam int ATB_DATA_W = 32;
   localparam int ATB_BYTE_W = $clog2(ATB_DATA_W) - 3;

   // Beat layout for the default 32-bit ATB configuration.
   typedef struct packed {
      logic [ATB_DATA_W-1:0] data;
      logic [ATB_BYTE_W-1:0] bytes;
      logic [ATB_ID_W-1:0]   id;
   } atb_beat_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      DRAIN = 2'd2,
      ACK   = 2'd3
   } funnel_fsm_e;

   // ID 0x00 and the 0x70-0x7F range never reach the sink.
   function automatic logic atb_id_dropped(input logic [ATB_ID_W-1:0] id);
      return (id == '0) || (id >= ATB_ID_RSVD_LO);
   endfunction

endpackage

// File: rtl/trenc_rr_arb.sv
// Round-robin arbiter with a registered grant and a per-grant beat budget of HOLD_MAX.
module trenc_rr_arb #(
   parameter int N        = 4,
   parameter int HOLD_MAX = 8
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [N-1:0]         req_i,
   input  logic                 beat_i,
   output logic [$clog2(N)-1:0] grant_o,
   output logic                 grant_vld_o
);

   localparam int GW = $clog2(N);
   localparam int CW = $clog2(HOLD_MAX + 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

   logic [GW-1:0] grant_q, grant_d, next_idx;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          found;
   logic          advance;

   // First requester after the current grant, wrapping; the current grant itself is checked last.
   always_comb begin
      int idx;
      idx      = 0;
      next_idx = grant_q;
      found    = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(grant_q) + k) % N;
         if (!found && req_i[GW'(idx)]) begin
            next_idx = GW'(idx);
            found    = 1'b1;
         end
      end
   end

   assign advance = !req_i[grant_q] || (beat_i && (cnt_q == HOLD_LAST));

   always_comb begin
      grant_d = grant_q;
      cnt_d   = cnt_q;
      if (advance) begin
         grant_d = next_idx;
         cnt_d   = '0;
      end else if (beat_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         grant_q <= '0;
         cnt_q   <= '0;
      end else begin
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant_o     = grant_q;
   assign grant_vld_o = req_i[grant_q];

endmodule

// File: rtl/trenc_atb_funnel.sv
// ATB funnel: merges NUM_SRC encoder streams through one registered slice and
// fans the sink flush request out to every enabled source.
module trenc_atb_funnel
   import trenc_pkg::*;
#(
   parameter int NUM_SRC  = 4,
   parameter int ATBWIDTH = 32,
   parameter int HOLD_MAX = 8
) (
   input  logic                                         trenc_atclk_i,
   input  logic                                         trenc_atrstn_i,
   input  logic [NUM_SRC-1:0]                           trenc_src_en_i,
   input  logic [NUM_SRC-1:0]                           s_atvalid_i,
   output logic [NUM_SRC-1:0]                           s_atready_o,
   input  logic [NUM_SRC-1:0][ATBWIDTH-1:0]             s_atdata_i,
   input  logic [NUM_SRC-1:0][$clog2(ATBWIDTH)-4:0]     s_atbyte_i,
   input  logic [NUM_SRC-1:0][ATB_ID_W-1:0]             s_atid_i,
   output logic [NUM_SRC-1:0]                           s_afvalid_o,
   input  logic [NUM_SRC-1:0]                           s_afready_i,
   output logic                                         m_atvalid_o,
   input  logic                                         m_atready_i,
   output logic [ATBWIDTH-1:0]                          m_atdata_o,
   output logic [$clog2(ATBWIDTH)-4:0]                  m_atbyte_o,
   output logic [ATB_ID_W-1:0]                          m_atid_o,
   input  logic                                         m_afvalid_i,
   output logic                                         m_afready_o
);

   localparam int GW = $clog2(NUM_SRC);
   localparam int BW = $clog2(ATBWIDTH) - 3;

   typedef struct packed {
      logic [ATBWIDTH-1:0] data;
      logic [BW-1:0]       bytes;
      logic [ATB_ID_W-1:0] id;
   } beat_t;

   logic [NUM_SRC-1:0] eligible;
   logic [GW-1:0]      grant;
   logic               grant_vld;
   logic               slot_free;
   logic               xfer;
   logic               load;

   beat_t              slice_q, slice_d;
   logic               valid_q, valid_d;

   funnel_fsm_e        state_q, state_d;
   logic [NUM_SRC-1:0] done_q, done_d;
   logic [NUM_SRC-1:0] afvalid;

   assign eligible  = s_atvalid_i & trenc_src_en_i;
   assign slot_free = !valid_q || m_atready_i;
   assign xfer      = grant_vld && slot_free;
   assign load      = xfer && !atb_id_dropped(s_atid_i[grant]);

   trenc_rr_arb #(
      .N        (NUM_SRC),
      .HOLD_MAX (HOLD_MAX)
   ) u_arb (
      .clk_i       (trenc_atclk_i),
      .rstn_i      (trenc_atrstn_i),
      .req_i       (eligible),
      .beat_i      (xfer),
      .grant_o     (grant),
      .grant_vld_o (grant_vld)
   );

   assign s_atready_o = xfer ? (NUM_SRC'(1) << grant) : '0;

   // Dropped-ID beats are handshaken with the source but never occupy the slice.
   always_comb begin
      valid_d = valid_q;
      slice_d = slice_q;
      if (load) begin
         valid_d       = 1'b1;
         slice_d.data  = s_atdata_i[grant];
         slice_d.bytes = s_atbyte_i[grant];
         slice_d.id    = s_atid_i[grant];
      end else if (m_atready_i) begin
         valid_d = 1'b0;
      end
   end

   assign afvalid = (state_q == FLUSH) ? (trenc_src_en_i & ~done_q) : '0;

   // Disabled sources count as flushed; DRAIN waits for the slice to be empty next cycle.
   always_comb begin
      state_d = state_q;
      done_d  = done_q;
      case (state_q)
         IDLE: begin
            if (m_afvalid_i) begin
               state_d = FLUSH;
               done_d  = '0;
            end
         end
         FLUSH: begin
            done_d = done_q | (afvalid & s_afready_i);
            if (&(done_d | ~trenc_src_en_i)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!valid_d) begin
               state_d = ACK;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge trenc_atclk_i) begin
      if (!trenc_atrstn_i) begin
         valid_q <= 1'b0;
         slice_q <= '0;
         state_q <= IDLE;
         done_q  <= '0;
      end else begin
         valid_q <= valid_d;
         slice_q <= slice_d;
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   assign m_atvalid_o = valid_q;
   assign m_atdata_o  = slice_q.data;
   assign m_atbyte_o  = slice_q.bytes;
   assign m_atid_o    = slice_q.id;
   assign s_afvalid_o = afvalid;
   assign m_afready_o = (state_q == ACK);

endmodule

// File: tb/tb_trenc_atb_funnel.sv
// Directed bench for trenc_atb_funnel: arbitration, stall, ID dropping, flush handshake and reset.
module tb_trenc_atb_funnel;

   logic            atClk = 1'b0;
   logic            atRstn;
   logic [3:0]      srcEn;
   logic [3:0]      sAtvalid;
   logic [3:0]      sAtready;
   logic [3:0][31:0] sAtdata;
   logic [3:0][1:0] sAtbyte;
   logic [3:0][6:0] sAtid;
   logic [3:0]      sAfvalid;
   logic [3:0]      sAfready;
   logic            mAtvalid;
   logic            mAtready;
   logic [31:0]     mAtdata;
   logic [1:0]      mAtbyte;
   logic [6:0]      mAtid;
   logic            mAfvalid;
   logic            mAfready;

   int checkCount = 0;
   int failCount  = 0;
   int c3Count    = 0;
   int ackPulses  = 0;
   int beat0;
   logic acc;
   logic [6:0] idList [4];
   logic       expVis [4];

   trenc_atb_funnel #(
      .NUM_SRC  (4),
      .ATBWIDTH (32),
      .HOLD_MAX (8)
   ) dut (
      .trenc_atclk_i  (atClk),
      .trenc_atrstn_i (atRstn),
      .trenc_src_en_i (srcEn),
      .s_atvalid_i    (sAtvalid),
      .s_atready_o    (sAtready),
      .s_atdata_i     (sAtdata),
      .s_atbyte_i     (sAtbyte),
      .s_atid_i       (sAtid),
      .s_afvalid_o    (sAfvalid),
      .s_afready_i    (sAfready),
      .m_atvalid_o    (mAtvalid),
      .m_atready_i    (mAtready),
      .m_atdata_o     (mAtdata),
      .m_atbyte_o     (mAtbyte),
      .m_atid_o       (mAtid),
      .m_afvalid_i    (mAfvalid),
      .m_afready_o    (mAfready)
   );

   always #5 atClk = ~atClk;

   // Sink-side monitor sampled mid-cycle, when the handshake about to happen is stable.
   always @(negedge atClk) begin
      if (mAtvalid && mAtready && mAtdata == 32'hC3C30003) c3Count++;
      if (mAfready) ackPulses++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge atClk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic sendBeat(input int src, input logic [6:0] id, input logic [31:0] data, output logic accepted);
      sAtvalid[src] = 1'b1;
      sAtid[src]    = id;
      sAtdata[src]  = data;
      sAtbyte[src]  = 2'd3;
      accepted      = 1'b0;
      for (int n = 0; n < 8 && !accepted; n++) begin
         #1;
         accepted = sAtready[src];
         applyStimulus(1);
      end
      sAtvalid[src] = 1'b0;
   endtask

   initial begin
      atRstn = 1'b0; srcEn = '0; sAtvalid = '0; sAtdata = '0; sAtbyte = '0; sAtid = '0;
      sAfready = '0; mAtready = 1'b0; mAfvalid = 1'b0;
      idList[0] = 7'h7A; idList[1] = 7'h70; idList[2] = 7'h00; idList[3] = 7'h6F;
      expVis[0] = 1'b0;  expVis[1] = 1'b0;  expVis[2] = 1'b0;  expVis[3] = 1'b1;

      applyStimulus(3);
      #1;
      checkOutput("rst_mvalid", mAtvalid, 1'b0);
      checkOutput("rst_sready", sAtready, 4'b0000);
      checkOutput("rst_afvalid", sAfvalid, 4'b0000);
      checkOutput("rst_afready", mAfready, 1'b0);
      checkOutput("rst_mdata", mAtdata, 32'h0);
      checkOutput("rst_mid", mAtid, 7'h0);
      checkOutput("rst_mbyte", mAtbyte, 2'h0);
      atRstn = 1'b1;
      srcEn  = 4'hF;
      applyStimulus(1);

      // Src0 streams under src1 contention: 8 beats, then rotation to src1.
      mAtready = 1'b1;
      sAtvalid = 4'b0011;
      sAtid[0] = 7'h10; sAtid[1] = 7'h11; sAtdata[1] = 32'hB1B1B1B1;
      sAtbyte[0] = 2'd3; sAtbyte[1] = 2'd3;
      beat0 = 0;
      for (int i = 0; i < 10; i++) begin
         sAtdata[0] = 32'hA0000000 + beat0;
         #1;
         checkOutput("hold_sready", sAtready, (i < 8) ? 4'b0001 : 4'b0010);
         checkOutput("hold_mvalid", mAtvalid, i > 0);
         if (i >= 1 && i <= 8) begin
            checkOutput("hold_mdata", mAtdata, 32'hA0000000 + i - 1);
            checkOutput("hold_mid", mAtid, 7'h10);
         end
         if (i == 9) begin
            checkOutput("rot_mdata", mAtdata, 32'hB1B1B1B1);
            checkOutput("rot_mid", mAtid, 7'h11);
         end
         if (sAtready[0]) beat0++;
         applyStimulus(1);
      end
      sAtvalid = '0;
      #1;
      checkOutput("tail_mvalid", mAtvalid, 1'b1);
      applyStimulus(1);
      #1;
      checkOutput("empty_mvalid", mAtvalid, 1'b0);

      // Stall: beat from src3 held in the slice for 5 cycles while src0 waits.
      mAtready = 1'b0;
      sAtvalid[3] = 1'b1; sAtid[3] = 7'h23; sAtdata[3] = 32'hC3C30003; sAtbyte[3] = 2'd3;
      #1;
      checkOutput("stall_regrant", sAtready, 4'b0000);
      applyStimulus(1);
      #1;
      checkOutput("stall_accept", sAtready, 4'b1000);
      applyStimulus(1);
      sAtvalid[3] = 1'b0;
      sAtvalid[0] = 1'b1; sAtid[0] = 7'h30; sAtdata[0] = 32'hD0D0D0D0; sAtbyte[0] = 2'd1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput("stall_mvalid", mAtvalid, 1'b1);
         checkOutput("stall_mdata", mAtdata, 32'hC3C30003);
         checkOutput("stall_mid", mAtid, 7'h23);
         checkOutput("stall_mbyte", mAtbyte, 2'd3);
         checkOutput("stall_sready", sAtready, 4'b0000);
         applyStimulus(1);
      end
      mAtready = 1'b1;
      #1;
      checkOutput("release_sready", sAtready, 4'b0001);
      checkOutput("release_mdata", mAtdata, 32'hC3C30003);
      applyStimulus(1);
      sAtvalid[0] = 1'b0;
      #1;
      checkOutput("next_mvalid", mAtvalid, 1'b1);
      checkOutput("next_mdata", mAtdata, 32'hD0D0D0D0);
      checkOutput("next_mid", mAtid, 7'h30);
      checkOutput("next_mbyte", mAtbyte, 2'd1);
      applyStimulus(1);
      #1;
      checkOutput("next_empty", mAtvalid, 1'b0);
      checkOutput("once_count", c3Count, 1);

      // Reserved / zero IDs are consumed silently; 0x6F is the last visible ID.
      for (int k = 0; k < 4; k++) begin
         sendBeat(2, idList[k], 32'h5A5A0000 | 32'(idList[k]), acc);
         checkOutput("drop_accepted", acc, 1'b1);
         #1;
         checkOutput("drop_visible", mAtvalid, expVis[k]);
         if (expVis[k]) checkOutput("drop_mid", mAtid, idList[k]);
         applyStimulus(1);
         #1;
         checkOutput("drop_after", mAtvalid, 1'b0);
      end

      // Flush with sources 0 and 2 enabled; src1 valid but disabled must never be served.
      srcEn = 4'b0101;
      sAtvalid[1] = 1'b1; sAtid[1] = 7'h11;
      sAtid[2] = 7'h22; sAtdata[2] = 32'hE2E2E2E2;
      for (int c = 0; c < 14; c++) begin
         mAfvalid    = (c == 0);
         sAfready    = (c == 2) ? 4'b0001 : (c == 6) ? 4'b0100 : 4'b0000;
         sAtvalid[2] = (c == 4);
         mAtready    = !(c >= 4 && c <= 8);
         #1;
         checkOutput("fl_afvalid", sAfvalid, (c == 1 || c == 2) ? 4'b0101 : (c >= 3 && c <= 6) ? 4'b0100 : 4'b0000);
         checkOutput("fl_afready", mAfready, c == 10);
         checkOutput("fl_sready", sAtready, (c == 4) ? 4'b0100 : 4'b0000);
         checkOutput("fl_mvalid", mAtvalid, c >= 5 && c <= 9);
         applyStimulus(1);
      end
      checkOutput("fl_pulses", ackPulses, 1);
      sAtvalid = '0;
      mAtready = 1'b0;

      // Reset while a beat sits in the slice and the FSM is flushing.
      mAfvalid = 1'b1;
      sAtvalid[0] = 1'b1; sAtid[0] = 7'h44; sAtdata[0] = 32'h66660000;
      #1;
      checkOutput("rf_wait", sAtready, 4'b0000);
      applyStimulus(1);
      mAfvalid = 1'b0;
      #1;
      checkOutput("rf_accept", sAtready, 4'b0001);
      checkOutput("rf_afvalid", sAfvalid, 4'b0101);
      applyStimulus(1);
      sAtvalid = '0;
      atRstn = 1'b0;
      #1;
      checkOutput("rf_full", mAtvalid, 1'b1);
      checkOutput("rf_flushing", sAfvalid, 4'b0101);
      applyStimulus(1);
      #1;
      checkOutput("rr_mvalid", mAtvalid, 1'b0);
      checkOutput("rr_mdata", mAtdata, 32'h0);
      checkOutput("rr_mid", mAtid, 7'h0);
      checkOutput("rr_mbyte", mAtbyte, 2'h0);
      checkOutput("rr_afvalid", sAfvalid, 4'b0000);
      checkOutput("rr_afready", mAfready, 1'b0);
      checkOutput("rr_sready", sAtready, 4'b0000);
      atRstn = 1'b1;
      mAtready = 1'b1;
      applyStimulus(1);
      #1;
      checkOutput("rr_noreplay", mAtvalid, 1'b0);
      checkOutput("rr_idle", sAfvalid, 4'b0000);

      // No enabled sources: FLUSH, DRAIN, then the ACK pulse.
      srcEn = 4'b0000;
      mAfvalid = 1'b1;
      applyStimulus(1);
      mAfvalid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         #1;
         checkOutput("noen_afready", mAfready, c == 3);
         checkOutput("noen_afvalid", sAfvalid, 4'b0000);
         applyStimulus(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
